// File: rtl/path_delay_meter_pkg.sv
// Shared definitions for path delay measurement: FSM state encoding and default sizing.
// The sweep top level imports this package as well.
package path_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10,
    ST_TMO   = 2'b11
  } meas_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TOL     = 2;
  localparam int DEF_TIMEOUT = 4095;

endpackage

// File: rtl/path_delay_meter_if.sv
// Control/result bundle between the path control FSM (master) and the delay meter (slave).
interface path_delay_meter_if #(
  parameter int CNT_W = 16
);
  logic             ld_reg;
  logic             fin;
  logic             cal_mode;
  logic             rearm;
  logic [CNT_W-1:0] delay_count;
  logic             done;
  logic             golden_valid;
  logic             trojan_flag;
  logic             timeout;

  modport master (
    output ld_reg, fin, cal_mode, rearm,
    input  delay_count, done, golden_valid, trojan_flag, timeout
  );

  modport slave (
    input  ld_reg, fin, cal_mode, rearm,
    output delay_count, done, golden_valid, trojan_flag, timeout
  );
endinterface

// File: rtl/path_delay_meter_compare.sv
// Combinational tolerance test: flags when the unsigned distance |a-b| exceeds TOL.
module delay_compare #(
  parameter int CNT_W = 16,
  parameter int TOL   = 2
) (
  input  logic [CNT_W-1:0] i_a,
  input  logic [CNT_W-1:0] i_b,
  output logic             o_exceeds
);

  localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);

  logic [CNT_W-1:0] w_diff;

  // Larger minus smaller so the difference can never wrap.
  always_comb begin
    w_diff    = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    o_exceeds = (w_diff > TOL_V);
  end

endmodule

// File: rtl/path_delay_meter.sv
// Measures the ld_reg-high interval of a path test, stores a golden count in calibration
// runs, and flags later runs whose delay strays from the golden value by more than TOL.
module path_delay_meter
  import path_meas_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOL     = DEF_TOL,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  path_delay_meter_if.slave      m
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  meas_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_golden;
  logic             r_golden_valid;
  logic             r_done;
  logic             r_trojan;
  logic             r_timeout;
  logic             w_exceeds;

  delay_compare #(
    .CNT_W (CNT_W),
    .TOL   (TOL)
  ) u_cmp (
    .i_a       (r_cnt),
    .i_b       (r_golden),
    .o_exceeds (w_exceeds)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_delay        <= '0;
      r_golden       <= '0;
      r_golden_valid <= 1'b0;
      r_done         <= 1'b0;
      r_trojan       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          // The cycle that sees ld_reg first is already part of the path delay.
          if (m.ld_reg) begin
            r_state <= ST_COUNT;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (m.fin) begin
            r_state <= ST_DONE;
            r_delay <= r_cnt;
            r_done  <= 1'b1;
            if (m.cal_mode) begin
              r_golden       <= r_cnt;
              r_golden_valid <= 1'b1;
              r_trojan       <= 1'b0;
            end else if (r_golden_valid) begin
              r_trojan <= w_exceeds;
            end else begin
              r_trojan <= 1'b0;
            end
          end else if (!m.ld_reg) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_V) begin
            r_state   <= ST_TMO;
            r_timeout <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (m.rearm) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        ST_TMO: begin
          if (m.rearm) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m.delay_count  = r_delay;
  assign m.done         = r_done;
  assign m.golden_valid = r_golden_valid;
  assign m.trojan_flag  = r_trojan;
  assign m.timeout      = r_timeout;

endmodule

// File: tb/tb_path_delay_meter.sv
// Scoreboard bench for path_delay_meter: directed runs push expected results, a negedge
// monitor pops them whenever done or timeout rises.
module tb_path_delay_meter;

  localparam int CNT_W = 16;

  typedef struct {
    logic [CNT_W-1:0] dc;
    logic             gv;
    logic             tf;
    logic             tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q[$];
  logic prev_done = 1'b0;
  logic prev_tmo  = 1'b0;

  always #5 clk = ~clk;

  path_delay_meter_if #(.CNT_W(CNT_W)) bus ();

  path_delay_meter #(
    .CNT_W   (CNT_W),
    .TOL     (2),
    .TIMEOUT (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int dc, input bit gv, input bit tf, input bit tmo);
    exp_t e;
    e.dc  = CNT_W'(dc);
    e.gv  = gv;
    e.tf  = tf;
    e.tmo = tmo;
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dc"},   32'(bus.delay_count), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_gv"},   32'(bus.golden_valid), 0);
    chk({tag, "_tf"},   32'(bus.trojan_flag), 0);
    chk({tag, "_tmo"},  32'(bus.timeout), 0);
  endtask

  task automatic rearm_pulse();
    bus.rearm = 1'b1;
    bus.fin   = 1'b0;
    tick();
    bus.rearm = 1'b0;
    chk("rearm_done_low", 32'(bus.done), 0);
  endtask

  // ld_reg high for n sampled cycles, then fin; expects done exactly one clock later.
  task automatic run(input int n, input bit cal, input int dc, input bit gv, input bit tf);
    int cyc;
    push(dc, gv, tf, 1'b0);
    bus.cal_mode = cal;
    bus.ld_reg   = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.ld_reg = 1'b0;
    bus.fin    = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.done && cyc < 6);
    chk("done_latency", 32'(cyc), 1);
    tick();
    rearm_pulse();
  endtask

  always @(negedge clk) begin
    if ((bus.done && !prev_done) || (bus.timeout && !prev_tmo)) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("delay_count",  32'(bus.delay_count), 32'(e.dc));
        chk("golden_valid", 32'(bus.golden_valid), 32'(e.gv));
        chk("trojan_flag",  32'(bus.trojan_flag), 32'(e.tf));
        chk("timeout",      32'(bus.timeout), 32'(e.tmo));
        chk("done",         32'(bus.done), 32'(!e.tmo));
      end
    end
    prev_done <= bus.done;
    prev_tmo  <= bus.timeout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.ld_reg   = 1'b0;
    bus.fin      = 1'b0;
    bus.cal_mode = 1'b0;
    bus.rearm    = 1'b0;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Calibration, then compares against golden 7 with TOL 2.
    run(7, 1'b1, 7, 1'b1, 1'b0);
    run(9, 1'b0, 9, 1'b1, 1'b0);
    run(10, 1'b0, 10, 1'b1, 1'b1);
    run(4, 1'b0, 4, 1'b1, 1'b1);
    run(5, 1'b0, 5, 1'b1, 1'b0);
    run(10, 1'b0, 10, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a count.
    bus.ld_reg = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid_count");
    bus.ld_reg = 1'b0;
    #3 rst = 1'b0;
    tick();

    // Compare without a golden value.
    run(5, 1'b0, 5, 1'b0, 1'b0);

    // Timeout: ld_reg never drops, fin never comes.
    push(5, 1'b0, 1'b0, 1'b1);
    bus.ld_reg = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.timeout && cyc < 40);
    chk("timeout_cycles", 32'(cyc), 21);
    tick();
    chk("tmo_done_low", 32'(bus.done), 0);
    bus.ld_reg = 1'b0;
    rearm_pulse();
    chk("tmo_cleared", 32'(bus.timeout), 0);

    // Asynchronous reset while sitting in DONE.
    push(6, 1'b1, 1'b0, 1'b0);
    bus.cal_mode = 1'b1;
    bus.ld_reg   = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.ld_reg = 1'b0;
    bus.fin    = 1'b1;
    tick();
    tick();
    chk("pre_rst_done", 32'(bus.done), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_in_done");
    #3 rst = 1'b0;
    tick();

    // Stray fin in IDLE must not start or finish anything.
    bus.fin = 1'b1;
    tick(); tick(); tick();
    chk("stray_fin_done", 32'(bus.done), 0);
    chk("stray_fin_tmo",  32'(bus.timeout), 0);
    chk("stray_fin_dc",   32'(bus.delay_count), 0);
    bus.fin = 1'b0;
    tick();
    run(3, 1'b0, 3, 1'b0, 1'b0);

    tick(); tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
